// File: rtl/lh_msg_feeder_pkg.sv
// lh_feeder_pkg: shared types and constants for the light_hash message feeder.
//   state_e      - feeder FSM states
//   err_code_e   - values reported on err_code_o
//   DIGEST_W     - width of the light_hash digest
//   START/END    - default framing bytes
package lh_feeder_pkg;

  localparam int         DIGEST_W       = 64;
  localparam logic [7:0] START_BYTE_DEF = 8'hFF;
  localparam logic [7:0] END_BYTE_DEF   = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_START,
    ST_GAP,
    ST_WAIT_IDLE,
    ST_SEND_DATA,
    ST_SEND_END,
    ST_WAIT_DIGEST
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_HASH_BYTE = 2'd1,
    ERR_TIMEOUT   = 2'd2,
    ERR_RESERVED  = 2'd3
  } err_code_e;

  // Framing bytes cannot appear inside a payload.
  function automatic logic is_reserved(input logic [7:0] b,
                                       input logic [7:0] start_b,
                                       input logic [7:0] end_b);
    return (b == start_b) || (b == end_b);
  endfunction

endpackage

// File: rtl/lh_msg_feeder_if.sv
// lh_msg_feeder_if: byte-stream link between the feeder and the light_hash core.
//   message_byte/message_valid    feeder -> hasher
//   hash_busy                     hasher "next_byte" busy flag
//   hash_digest/hash_digest_ready hasher result
//   hash_err                      hasher rejected the last byte
// master = feeder side, slave = hasher side.
interface lh_msg_feeder_if;
  import lh_feeder_pkg::*;

  logic [7:0]          message_byte;
  logic                message_valid;
  logic                hash_busy;
  logic [DIGEST_W-1:0] hash_digest;
  logic                hash_digest_ready;
  logic                hash_err;

  modport master (
    output message_byte, message_valid,
    input  hash_busy, hash_digest, hash_digest_ready, hash_err
  );

  modport slave (
    input  message_byte, message_valid,
    output hash_busy, hash_digest, hash_digest_ready, hash_err
  );

endinterface

// File: rtl/lh_msg_buffer.sv
// lh_msg_buffer: MAX_LEN x 8 payload storage.
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address (the feeder's byte count)
//   wr_data_i  byte to store
//   rd_addr_i  read address (the feeder's read pointer)
//   rd_data_o  combinational read data
// No reset: contents are only meaningful below the feeder's count.
module lh_msg_buffer #(
  parameter int MAX_LEN = 32,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);
  import lh_feeder_pkg::*;

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lh_msg_feeder.sv
// lh_msg_feeder: buffers a host-loaded message and streams it into light_hash
// framed as START_BYTE, payload, END_BYTE, then captures the digest.
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_byte_i/_valid_i/load_ready_o   host payload write port
//   start_i             one-cycle request to send the buffered message
//   hash_if             link to light_hash (master side)
//   digest_out_o        digest of the last completed message
//   done_o              pulse when digest_out_o updates
//   err_code_o          0 none, 1 hasher rejected byte, 2 timeout, 3 reserved byte
//   err_pulse_o         pulse with each new non-zero err_code_o
//   busy_o              FSM not idle
//
// state          | meaning
// ---------------+---------------------------------------------------
// ST_IDLE        | accept payload bytes, wait for start
// ST_SEND_START  | message_valid high with START_BYTE
// ST_GAP         | valid low; check hasher error for the byte just sent
// ST_WAIT_IDLE   | wait for hash_busy low, pick next byte or finish
// ST_SEND_DATA   | message_valid high with a payload byte
// ST_SEND_END    | message_valid high with END_BYTE
// ST_WAIT_DIGEST | wait for digest_ready, bounded by TIMEOUT_CYC
module lh_msg_feeder #(
  parameter int         MAX_LEN     = 32,
  parameter logic [7:0] START_BYTE  = lh_feeder_pkg::START_BYTE_DEF,
  parameter logic [7:0] END_BYTE    = lh_feeder_pkg::END_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [7:0]                        load_byte_i,
  input  logic                              load_valid_i,
  output logic                              load_ready_o,
  input  logic                              start_i,
  lh_msg_feeder_if.master                   hash_if,
  output logic [lh_feeder_pkg::DIGEST_W-1:0] digest_out_o,
  output logic                              done_o,
  output logic [1:0]                        err_code_o,
  output logic                              err_pulse_o,
  output logic                              busy_o
);
  import lh_feeder_pkg::*;

  // count/rd_ptr carry one extra bit so a full buffer (count == MAX_LEN) is representable.
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int AW    = $clog2(MAX_LEN);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    rd_ptr_q;
  logic [TMR_W-1:0]    tmr_q;
  logic                end_sent_q;
  logic [7:0]          msg_byte_q;
  logic                msg_valid_q;
  logic [DIGEST_W-1:0] digest_q;
  logic                done_q;
  err_code_e           err_code_q;
  logic                err_pulse_q;

  logic       load_fire;
  logic       load_rsvd;
  logic       buf_wr_en;
  logic [7:0] buf_rd_data;

  assign load_ready_o = (state_q == ST_IDLE) && (count_q < CNT_W'(MAX_LEN));
  assign load_fire    = load_valid_i && load_ready_o;
  assign load_rsvd    = load_fire && is_reserved(load_byte_i, START_BYTE, END_BYTE);
  assign buf_wr_en    = load_fire && !load_rsvd;

  lh_msg_buffer #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk_i     (clk_i),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (count_q[AW-1:0]),
    .wr_data_i (load_byte_i),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (buf_rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      tmr_q       <= '0;
      end_sent_q  <= 1'b0;
      msg_byte_q  <= '0;
      msg_valid_q <= 1'b0;
      digest_q    <= '0;
      done_q      <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_pulse_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (buf_wr_en) count_q <= count_q + CNT_W'(1);
          if (start_i) begin
            state_q     <= ST_SEND_START;
            msg_valid_q <= 1'b1;
            msg_byte_q  <= START_BYTE;
            rd_ptr_q    <= '0;
            end_sent_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
          end
          // A reserved byte in the same cycle as start still gets reported.
          if (load_rsvd) begin
            err_code_q  <= ERR_RESERVED;
            err_pulse_q <= 1'b1;
          end
        end
        ST_SEND_START, ST_SEND_DATA, ST_SEND_END: begin
          msg_valid_q <= 1'b0;
          state_q     <= ST_GAP;
        end
        ST_GAP: begin
          if (hash_if.hash_err) begin
            err_code_q  <= ERR_HASH_BYTE;
            err_pulse_q <= 1'b1;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (!hash_if.hash_busy) begin
            if (end_sent_q) begin
              tmr_q   <= '0;
              state_q <= ST_WAIT_DIGEST;
            end else if (rd_ptr_q < count_q) begin
              msg_valid_q <= 1'b1;
              msg_byte_q  <= buf_rd_data;
              rd_ptr_q    <= rd_ptr_q + CNT_W'(1);
              state_q     <= ST_SEND_DATA;
            end else begin
              msg_valid_q <= 1'b1;
              msg_byte_q  <= END_BYTE;
              end_sent_q  <= 1'b1;
              state_q     <= ST_SEND_END;
            end
          end
        end
        ST_WAIT_DIGEST: begin
          // Ready takes priority over a timeout in the same cycle.
          if (hash_if.hash_digest_ready) begin
            digest_q <= hash_if.hash_digest;
            done_q   <= 1'b1;
            count_q  <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_IDLE;
          end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            err_code_q  <= ERR_TIMEOUT;
            err_pulse_q <= 1'b1;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hash_if.message_byte  = msg_byte_q;
  assign hash_if.message_valid = msg_valid_q;
  assign digest_out_o          = digest_q;
  assign done_o                = done_q;
  assign err_code_o            = err_code_q;
  assign err_pulse_o           = err_pulse_q;
  assign busy_o                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lh_msg_feeder.sv
module tb_lh_msg_feeder;
  import lh_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  load_byte_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic        start_i;
  logic [63:0] digest_out_o;
  logic        done_o;
  logic [1:0]  err_code_o;
  logic        err_pulse_o;
  logic        busy_o;

  always #5 clk = ~clk;

  lh_msg_feeder_if hif ();

  lh_msg_feeder #(.MAX_LEN(32), .TIMEOUT_CYC(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_byte_i  (load_byte_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .start_i      (start_i),
    .hash_if      (hif),
    .digest_out_o (digest_out_o),
    .done_o       (done_o),
    .err_code_o   (err_code_o),
    .err_pulse_o  (err_pulse_o),
    .busy_o       (busy_o)
  );

  // ---------------- stub hasher ----------------
  int          busy_len;
  logic        err_inject;
  logic [7:0]  err_byte;
  logic        digest_en;
  logic [63:0] stub_digest;
  logic [7:0]  bcnt;
  logic        end_seen, st_err, st_rdy;
  logic [63:0] st_dig;

  always @(posedge clk) begin
    if (rst_i) begin
      bcnt <= '0; end_seen <= 1'b0; st_err <= 1'b0; st_rdy <= 1'b0; st_dig <= '0;
    end else begin
      st_err <= 1'b0;
      if (hif.message_valid) begin
        bcnt   <= 8'(busy_len);
        st_rdy <= 1'b0;
        if (hif.message_byte == 8'h00) end_seen <= 1'b1;
        if (hif.message_byte == 8'hFF) end_seen <= 1'b0;
        if (err_inject && hif.message_byte == err_byte) st_err <= 1'b1;
      end else if (bcnt != 0) begin
        bcnt <= bcnt - 8'd1;
      end else if (end_seen && digest_en) begin
        st_rdy   <= 1'b1;
        st_dig   <= stub_digest;
        end_seen <= 1'b0;
      end
    end
  end

  assign hif.hash_busy         = (bcnt != 0);
  assign hif.hash_err          = st_err;
  assign hif.hash_digest_ready = st_rdy;
  assign hif.hash_digest       = st_dig;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_bytes[$];
  logic [63:0] exp_dig[$];
  logic [1:0]  exp_err[$];
  int since;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      since <= 100;
    end else begin
      if (hif.message_valid) begin
        check("valid_spacing_not_busy", 64'(since >= 2 && !hif.hash_busy), 64'd1);
        since <= 0;
        if (exp_bytes.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL frame_byte: got %h expected no byte", hif.message_byte);
        end else check("frame_byte", 64'(hif.message_byte), 64'(exp_bytes.pop_front()));
      end else if (since < 100) begin
        since <= since + 1;
      end
      if (done_o) begin
        if (exp_dig.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_digest: got %h expected no done", digest_out_o);
        end else check("done_digest", digest_out_o, exp_dig.pop_front());
      end
      if (err_pulse_o) begin
        if (exp_err.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL err_pulse: got code %0d expected no pulse", err_code_o);
        end else check("err_code_on_pulse", 64'(err_code_o), 64'(exp_err.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_one(input logic [7:0] b);
    load_byte_i = b; load_valid_i = 1'b1;
    @(posedge clk); #1;
    load_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy_o && k < 3000) begin @(posedge clk); #1; k++; end
    check({name, "_reaches_idle"}, 64'(busy_o), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic send_msg(input string s, input logic [63:0] dig);
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < s.len(); i++) begin
      exp_bytes.push_back(s[i]);
      load_one(s[i]);
    end
    exp_bytes.push_back(8'h00);
    exp_dig.push_back(dig);
    stub_digest = dig;
    pulse_start();
    wait_idle("msg");
  endtask

  task automatic wait_valid_byte(input logic [7:0] b, input string name);
    int k = 0;
    while (!(hif.message_valid && hif.message_byte == b) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check(name, 64'(hif.message_valid && hif.message_byte == b), 64'd1);
  endtask

  initial begin
    int k, np;
    string s;
    rst_i = 1'b1; load_byte_i = '0; load_valid_i = 1'b0; start_i = 1'b0;
    busy_len = 1; err_inject = 1'b0; err_byte = 8'h09; digest_en = 1'b1; stub_digest = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // reset state
    check("rst_load_ready", 64'(load_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(hif.message_valid), 64'd0);
    check("rst_msg_byte", 64'(hif.message_byte), 64'd0);
    check("rst_digest", digest_out_o, 64'd0);
    check("rst_err_code", 64'(err_code_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);

    // basic message
    send_msg("H4rdw4r3_Tr0j4n", 64'h5aecbf4f5fe467bc);
    check("msg1_digest", digest_out_o, 64'h5aecbf4f5fe467bc);
    check("msg1_err_code", 64'(err_code_o), 64'd0);

    // two back-to-back messages, different hasher pacing
    busy_len = 2;
    send_msg("AlessandroAndGiacomo", 64'he19e79abcdf021f1);
    busy_len = 5;
    send_msg("3.141592653589793238", 64'hf9e317d512022e21);
    check("msg3_digest", digest_out_o, 64'hf9e317d512022e21);

    // hasher rejects a tab mid-message
    busy_len = 3; err_inject = 1'b1; err_byte = 8'h09;
    s = "ab";
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < s.len(); i++) begin exp_bytes.push_back(s[i]); load_one(s[i]); end
    exp_bytes.push_back(8'h09); load_one(8'h09);
    load_one("c"); load_one("d");
    exp_err.push_back(2'd1);
    pulse_start();
    wait_valid_byte(8'h09, "hash_err_byte_sent");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hash_err_busy_low", 64'(busy_o), 64'd0);
    check("hash_err_code", 64'(err_code_o), 64'd1);
    check("hash_err_load_ready", 64'(load_ready_o), 64'd1);
    check("hash_err_digest_kept", digest_out_o, 64'hf9e317d512022e21);
    err_inject = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    // fill buffer to MAX_LEN, extra byte dropped
    busy_len = 0;
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < 32; i++) begin
      check("fill_load_ready", 64'(load_ready_o), 64'd1);
      exp_bytes.push_back(8'h41 + 8'(i));
      load_one(8'h41 + 8'(i));
    end
    check("full_load_ready_low", 64'(load_ready_o), 64'd0);
    load_one(8'h5A);
    check("full_still_not_ready", 64'(load_ready_o), 64'd0);
    exp_bytes.push_back(8'h00);
    exp_dig.push_back(64'h0123456789abcdef);
    stub_digest = 64'h0123456789abcdef;
    pulse_start();
    wait_idle("full");
    check("full_digest", digest_out_o, 64'h0123456789abcdef);

    // reserved bytes rejected at load
    busy_len = 1;
    load_one("x"); load_one("y");
    exp_err.push_back(2'd3);
    load_one(8'hFF);
    check("rsvd_ff_code", 64'(err_code_o), 64'd3);
    load_one("z");
    exp_err.push_back(2'd3);
    load_one(8'h00);
    check("rsvd_00_code", 64'(err_code_o), 64'd3);
    exp_bytes.push_back(8'hFF); exp_bytes.push_back("x"); exp_bytes.push_back("y");
    exp_bytes.push_back("z"); exp_bytes.push_back(8'h00);
    exp_dig.push_back(64'hfeedfacecafebabe);
    stub_digest = 64'hfeedfacecafebabe;
    pulse_start();
    wait_idle("rsvd");
    check("rsvd_frame_clears_err", 64'(err_code_o), 64'd0);
    check("rsvd_digest", digest_out_o, 64'hfeedfacecafebabe);

    // digest timeout
    busy_len = 3; digest_en = 1'b0;
    load_one("t"); load_one("o");
    exp_bytes.push_back(8'hFF); exp_bytes.push_back("t"); exp_bytes.push_back("o");
    exp_bytes.push_back(8'h00);
    exp_err.push_back(2'd2);
    pulse_start();
    wait_valid_byte(8'h00, "timeout_end_sent");
    k = 0;
    while (!err_pulse_o && k < 100) begin @(posedge clk); #1; k++; end
    check("timeout_latency", 64'(k), 64'd21);
    check("timeout_code", 64'(err_code_o), 64'd2);
    check("timeout_digest_kept", digest_out_o, 64'hfeedfacecafebabe);
    wait_idle("timeout");
    digest_en = 1'b1;

    // reset in WAIT_IDLE after payload byte 5
    busy_len = 4;
    s = "reset!";
    for (int i = 0; i < s.len(); i++) load_one(s[i]);
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < 5; i++) exp_bytes.push_back(s[i]);
    pulse_start();
    np = hif.message_valid ? 1 : 0;
    k = 0;
    while (np < 6 && k < 500) begin
      @(posedge clk); #1; k++;
      if (hif.message_valid) np++;
    end
    check("rst_mid_pulses", 64'(np), 64'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst_mid_valid", 64'(hif.message_valid), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_digest", digest_out_o, 64'd0);
    check("rst_mid_load_ready", 64'(load_ready_o), 64'd1);
    check("rst_mid_err_code", 64'(err_code_o), 64'd0);
    repeat (2) begin @(posedge clk); #1; end

    // empty message after reset
    busy_len = 2;
    send_msg("", 64'h1122334455667788);
    check("empty_digest", digest_out_o, 64'h1122334455667788);

    repeat (4) begin @(posedge clk); #1; end
    check("bytes_drained", 64'(exp_bytes.size()), 64'd0);
    check("digests_drained", 64'(exp_dig.size()), 64'd0);
    check("errs_drained", 64'(exp_err.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000ns");
    $fatal(1, "watchdog");
  end

endmodule
